gpio_msg_receiver: RTL and testbench

GPIO_MSG_RECEIVER -- requirements
Module: gpio_msg_receiver

---
 rtl/gpio_msg_receiver.sv | 163 ++++++++++++++++
 tb/tb_gpio_msg_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_msg_receiver.sv
// rtl/gpio_msg_receiver.sv - GPIO four-phase message receiver with show-ahead payload FIFO
//
// Receives framed 16-bit words from a sender over a four-phase req/ack handshake.
// Frame: header {SYNC_BYTE, LEN}, LEN payload words, XOR checksum word.
// Payload words are queued in a show-ahead FIFO; frame status is reported as
// one-cycle frame_ok / frame_err pulses.
//
// Ports:
//   clock      in   1   shared GPIO clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   gpio_data  in  16   message word, held stable by sender during handshake
//   gpio_req   in   1   sender word-request strobe (asynchronous)
//   gpio_ack   out  1   word acknowledge to sender
//   msg_data   out 16   FIFO head payload word
//   msg_last   out  1   FIFO head is last payload word of its frame
//   msg_valid  out  1   FIFO not empty
//   msg_ready  in   1   consumer accepts head word
//   frame_ok   out  1   one-cycle pulse, checksum matched
//   frame_err  out  1   one-cycle pulse, header or checksum error
//   busy       out  1   state is not IDLE

module gpio_msg_receiver #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] gpio_data,
    input  logic        gpio_req,
    output logic        gpio_ack,
    output logic [15:0] msg_data,
    output logic        msg_last,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t      r_state;
    logic        r_req_meta;
    logic        r_req_s;
    logic        r_ack;
    logic        r_ack_pend;
    logic [7:0]  r_count;
    logic [15:0] r_xor;
    logic        r_ok;
    logic        r_err;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [16:0] r_mem [FIFO_DEPTH];

    logic w_empty;
    logic w_full;
    logic w_allowed;
    logic w_capture;
    logic w_push;
    logic w_pop;
    logic w_last;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Only payload words need FIFO room; full is the pre-pop flag.
    assign w_allowed = !((r_state == S_PAYLOAD) && w_full);
    // r_ack_pend covers the cycle between capture and ack rising so the
    // same request is not captured twice.
    assign w_capture = r_req_s && !r_ack && !r_ack_pend && w_allowed;
    assign w_push    = w_capture && (r_state == S_PAYLOAD);
    assign w_pop     = !w_empty && msg_ready;
    assign w_last    = (r_count == 8'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
            r_ack      <= 1'b0;
            r_ack_pend <= 1'b0;
            r_count    <= 8'd0;
            r_xor      <= 16'd0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_req_meta <= gpio_req;
            r_req_s    <= r_req_meta;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;

            if (r_ack_pend) begin
                r_ack      <= 1'b1;
                r_ack_pend <= 1'b0;
            end else if (r_ack && !r_req_s) begin
                r_ack <= 1'b0;
            end

            if (w_capture) begin
                r_ack_pend <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if ((gpio_data[15:8] == SYNC_BYTE) && (gpio_data[7:0] != 8'd0)) begin
                            r_count <= gpio_data[7:0];
                            r_xor   <= 16'd0;
                            r_state <= S_PAYLOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        r_xor   <= r_xor ^ gpio_data;
                        r_count <= r_count - 8'd1;
                        if (w_last) begin
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (gpio_data == r_xor) begin
                            r_ok <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: outputs are gated by the empty flag.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_last, gpio_data};
        end
    end

    assign gpio_ack  = r_ack;
    assign msg_valid = !w_empty;
    assign msg_data  = w_empty ? 16'd0 : r_mem[r_rd_ptr[AW-1:0]][15:0];
    assign msg_last  = !w_empty && r_mem[r_rd_ptr[AW-1:0]][16];
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gpio_msg_receiver.sv
// tb/tb_gpio_msg_receiver.sv - self-checking bench for gpio_msg_receiver

module tb_gpio_msg_receiver;

    logic        clock;
    logic        resetn;
    logic [15:0] gpio_data;
    logic        gpio_req;
    logic        gpio_ack;
    logic [15:0] msg_data;
    logic        msg_last;
    logic        msg_valid;
    logic        msg_ready;
    logic        frame_ok;
    logic        frame_err;
    logic        busy;

    int total;
    int bad;

    int ok_cnt;
    int err_cnt;
    int both_cnt;
    int busy_cnt;
    logic [16:0] got_q[$];

    gpio_msg_receiver dut (
        .clock     (clock),
        .resetn    (resetn),
        .gpio_data (gpio_data),
        .gpio_req  (gpio_req),
        .gpio_ack  (gpio_ack),
        .msg_data  (msg_data),
        .msg_last  (msg_last),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (msg_valid && msg_ready) got_q.push_back({msg_last, msg_data});
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ack(input logic lvl, input int limit, output int n);
        int i;
        bit done;
        n = -1;
        done = 1'b0;
        i = 0;
        while (!done && i < limit) begin
            @(negedge clock);
            i++;
            if (gpio_ack == lvl) begin
                n = i;
                done = 1'b1;
            end
        end
    endtask

    task automatic send_word(input logic [15:0] d, output int rise_n, output int fall_n);
        @(negedge clock);
        gpio_data = d;
        gpio_req  = 1'b1;
        wait_ack(1'b1, 40, rise_n);
        gpio_req = 1'b0;
        wait_ack(1'b0, 40, fall_n);
    endtask

    task automatic send_chk(input string tag, input logic [15:0] d);
        int r;
        int f;
        send_word(d, r, f);
        chk(tag, {31'd0, (r > 0 && f > 0)}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int r, f, ok0, err0, busy0, base, acked, n;
        logic [15:0] w [10];
        logic [15:0] x;

        total = 0;
        bad = 0;
        ok_cnt = 0;
        err_cnt = 0;
        both_cnt = 0;
        busy_cnt = 0;
        resetn = 1'b0;
        gpio_data = 16'd0;
        gpio_req = 1'b0;
        msg_ready = 1'b0;
        idle(3);

        chk("rst_ack", {31'd0, gpio_ack}, 32'd0);
        chk("rst_valid", {31'd0, msg_valid}, 32'd0);
        chk("rst_last", {31'd0, msg_last}, 32'd0);
        chk("rst_data", {16'd0, msg_data}, 32'd0);
        chk("rst_ok_err", {30'd0, frame_ok, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        idle(2);

        // Good frame with latency measurement on the header word
        msg_ready = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt; base = got_q.size();
        send_word(16'hA503, r, f);
        chk("lat_rise", r, 4);
        chk("lat_fall", f, 3);
        chk("busy_hdr", {31'd0, busy}, 32'd1);
        send_chk("a_w1", 16'h1111);
        send_chk("a_w2", 16'h2222);
        send_chk("a_w3", 16'h4444);
        send_chk("a_ck", 16'h7777);
        idle(3);
        chk("a_cnt", got_q.size() - base, 3);
        chk("a_d0", {15'd0, got_q[base]},   {15'd0, 17'h01111});
        chk("a_d1", {15'd0, got_q[base+1]}, {15'd0, 17'h02222});
        chk("a_d2", {15'd0, got_q[base+2]}, {15'd0, 17'h14444});
        chk("a_ok", ok_cnt - ok0, 1);
        chk("a_err", err_cnt - err0, 0);
        chk("a_busy", {31'd0, busy}, 32'd0);

        // Bad checksum
        ok0 = ok_cnt; err0 = err_cnt; base = got_q.size();
        send_chk("b_hdr", 16'hA503);
        send_chk("b_w1", 16'h1111);
        send_chk("b_w2", 16'h2222);
        send_chk("b_w3", 16'h4444);
        send_chk("b_ck", 16'h7776);
        idle(3);
        chk("b_cnt", got_q.size() - base, 3);
        chk("b_d2", {15'd0, got_q[base+2]}, {15'd0, 17'h14444});
        chk("b_err", err_cnt - err0, 1);
        chk("b_ok", ok_cnt - ok0, 0);

        // Bad headers
        msg_ready = 1'b0;
        err0 = err_cnt; busy0 = busy_cnt;
        send_chk("c_h1", 16'h5A02);
        send_chk("c_h2", 16'hA500);
        idle(3);
        chk("c_err", err_cnt - err0, 2);
        chk("c_valid", {31'd0, msg_valid}, 32'd0);
        chk("c_busy", busy_cnt - busy0, 0);

        // Backpressure: 10 payload words into an 8-deep FIFO
        ok0 = ok_cnt; base = got_q.size();
        x = 16'd0;
        for (int i = 0; i < 10; i++) begin
            w[i] = 16'h0101 * 16'(i + 1) ^ 16'h3000;
            x = x ^ w[i];
        end
        send_chk("d_hdr", 16'hA50A);
        acked = 0;
        for (int i = 0; i < 8; i++) begin
            send_word(w[i], r, f);
            if (r > 0 && f > 0) acked++;
        end
        chk("d_acked8", acked, 8);
        @(negedge clock);
        gpio_data = w[8];
        gpio_req = 1'b1;
        idle(30);
        chk("d_blocked", {31'd0, gpio_ack}, 32'd0);
        chk("d_head", {16'd0, msg_data}, {16'd0, w[0]});
        msg_ready = 1'b1;
        @(negedge clock);
        msg_ready = 1'b0;
        wait_ack(1'b1, 40, n);
        chk("d_w9_ack", {31'd0, n > 0}, 32'd1);
        gpio_req = 1'b0;
        wait_ack(1'b0, 40, n);
        chk("d_w9_rel", {31'd0, n > 0}, 32'd1);
        msg_ready = 1'b1;
        send_chk("d_w10", w[9]);
        send_chk("d_ck", x);
        idle(12);
        chk("d_cnt", got_q.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("d_out%0d", i), {15'd0, got_q[base+i]},
                {15'd0, (i == 9), w[i]});
        end
        chk("d_ok", ok_cnt - ok0, 1);

        // Reset mid-frame
        ok0 = ok_cnt; err0 = err_cnt;
        send_chk("e_hdr", 16'hA504);
        send_chk("e_w1", 16'h0001);
        msg_ready = 1'b0;
        send_chk("e_w2", 16'h0002);
        chk("e_pre_valid", {31'd0, msg_valid}, 32'd1);
        resetn = 1'b0;
        idle(2);
        chk("e_rst_outs", {12'd0, gpio_ack, msg_valid, msg_last, frame_ok, frame_err, busy, msg_data},
            32'd0);
        resetn = 1'b1;
        idle(2);
        chk("e_no_pulse", (ok_cnt - ok0) + (err_cnt - err0), 0);
        msg_ready = 1'b1;
        base = got_q.size();
        send_chk("e_h1", 16'hA501);
        send_chk("e_p1", 16'hBEEF);
        send_chk("e_c1", 16'hBEEF);
        idle(3);
        chk("e_cnt", got_q.size() - base, 1);
        chk("e_word", {15'd0, got_q[base]}, {15'd0, 17'h1BEEF});
        chk("e_ok", ok_cnt - ok0, 1);
        chk("e_err", err_cnt - err0, 0);

        chk("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
